spi_ram_arbiter: RTL and testbench

Two-port arbiter and transaction sequencer for the shared external SPI RAM on the uio pins (CS_N, MOSI, MISO, SCK). It accepts byte-wide read/write requests from two requesters, such as the CPU instruction-fetch port and the data port. It grants one request at a time, round-robin, and runs one complete 23LC-style SPI transaction per grant: command byte, 16-bit address, one data byte. It sits between the CPU core and the pin mapping in the top-level wrapper.

---
 rtl/spi_ram_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_spi_ram_arbiter.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_ram_arbiter.sv
// Round-robin two-port arbiter that runs one 23LC-style SPI byte transaction
// (command, 16-bit address, one data byte) per grant on the shared external RAM.
module spi_ram_arbiter #(
  parameter int SCK_HALF = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic [15:0] addr0,
  input  logic [15:0] addr1,
  input  logic [7:0]  wdata0,
  input  logic [7:0]  wdata1,
  output logic        ack0,
  output logic        ack1,
  output logic [7:0]  rdata,
  output logic        busy,
  output logic        spi_cs_n,
  output logic        spi_sck,
  output logic        spi_mosi,
  input  logic        spi_miso
);

  // state    | meaning
  // IDLE     | bus released, arbitrate between req0/req1
  // CS_SETUP | cs_n low, first bit on mosi, sck low
  // SHIFT    | 32 bits MSB first, 2*SCK_HALF clk per bit
  // CS_HOLD  | cs_n still low after last falling sck
  // DONE     | cs_n high, ack pulse to the granted port

  localparam int HW = (SCK_HALF > 1) ? $clog2(SCK_HALF) : 1;
  localparam logic [HW-1:0] HALF_LOAD = HW'(SCK_HALF - 1);

  typedef enum logic [2:0] {
    IDLE,
    CS_SETUP,
    SHIFT,
    CS_HOLD,
    DONE
  } state_t;

  state_t        state, state_nxt;
  logic [31:0]   shift_q, shift_nxt;
  logic [4:0]    bit_q, bit_nxt;
  logic [HW-1:0] half_q, half_nxt;
  logic          phase_q, phase_nxt;
  logic [7:0]    rx_q, rx_nxt;
  logic [7:0]    rdata_nxt;
  logic          we_q, we_nxt;
  logic          grant_q, grant_nxt;
  logic          last_q, last_nxt;
  logic          take1;
  logic          ack0_nxt, ack1_nxt, busy_nxt, cs_n_nxt, sck_nxt, mosi_nxt;

  always_comb begin
    state_nxt = state;
    shift_nxt = shift_q;
    bit_nxt   = bit_q;
    half_nxt  = half_q;
    phase_nxt = phase_q;
    rx_nxt    = rx_q;
    rdata_nxt = rdata;
    we_nxt    = we_q;
    grant_nxt = grant_q;
    last_nxt  = last_q;
    take1     = 1'b0;

    case (state)
      IDLE: begin
        if (req0 || req1) begin
          // On a tie the port that was not served last wins.
          take1     = req1 && (!req0 || !last_q);
          grant_nxt = take1;
          last_nxt  = take1;
          if (take1) begin
            we_nxt    = we1;
            shift_nxt = {(we1 ? 8'h02 : 8'h03), addr1, (we1 ? wdata1 : 8'h00)};
          end else begin
            we_nxt    = we0;
            shift_nxt = {(we0 ? 8'h02 : 8'h03), addr0, (we0 ? wdata0 : 8'h00)};
          end
          state_nxt = CS_SETUP;
        end
      end

      CS_SETUP: begin
        state_nxt = SHIFT;
        half_nxt  = HALF_LOAD;
        phase_nxt = 1'b0;
        bit_nxt   = 5'd0;
      end

      SHIFT: begin
        if (half_q != '0) begin
          half_nxt = half_q - 1'b1;
        end else begin
          half_nxt = HALF_LOAD;
          if (!phase_q) begin
            phase_nxt = 1'b1;
            if (bit_q[4:3] == 2'b11) begin
              rx_nxt = {rx_q[6:0], spi_miso};
            end
          end else begin
            phase_nxt = 1'b0;
            if (bit_q == 5'd31) begin
              state_nxt = CS_HOLD;
            end else begin
              bit_nxt   = bit_q + 1'b1;
              shift_nxt = {shift_q[30:0], 1'b0};
            end
          end
        end
      end

      CS_HOLD: begin
        state_nxt = DONE;
        if (!we_q) begin
          rdata_nxt = rx_q;
        end
      end

      DONE: begin
        state_nxt = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase

    // Pin values are derived from the next state so they leave a flop directly.
    busy_nxt = (state_nxt != IDLE);
    cs_n_nxt = !((state_nxt == CS_SETUP) || (state_nxt == SHIFT) || (state_nxt == CS_HOLD));
    sck_nxt  = (state_nxt == SHIFT) && phase_nxt;
    mosi_nxt = ((state_nxt == CS_SETUP) || (state_nxt == SHIFT)) && shift_nxt[31];
    ack0_nxt = (state_nxt == DONE) && !grant_nxt;
    ack1_nxt = (state_nxt == DONE) && grant_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      shift_q  <= '0;
      bit_q    <= '0;
      half_q   <= '0;
      phase_q  <= 1'b0;
      rx_q     <= '0;
      rdata    <= '0;
      we_q     <= 1'b0;
      grant_q  <= 1'b0;
      last_q   <= 1'b1;
      ack0     <= 1'b0;
      ack1     <= 1'b0;
      busy     <= 1'b0;
      spi_cs_n <= 1'b1;
      spi_sck  <= 1'b0;
      spi_mosi <= 1'b0;
    end else begin
      state    <= state_nxt;
      shift_q  <= shift_nxt;
      bit_q    <= bit_nxt;
      half_q   <= half_nxt;
      phase_q  <= phase_nxt;
      rx_q     <= rx_nxt;
      rdata    <= rdata_nxt;
      we_q     <= we_nxt;
      grant_q  <= grant_nxt;
      last_q   <= last_nxt;
      ack0     <= ack0_nxt;
      ack1     <= ack1_nxt;
      busy     <= busy_nxt;
      spi_cs_n <= cs_n_nxt;
      spi_sck  <= sck_nxt;
      spi_mosi <= mosi_nxt;
    end
  end

endmodule

// File: tb/tb_spi_ram_arbiter.sv
// Bench for spi_ram_arbiter: one instance at SCK_HALF=1, one at SCK_HALF=2, each
// with an SPI RAM slave model that logs the MOSI stream and serves a read byte.
module tb_spi_ram_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  rst_v = 2'b11;
  logic [1:0]  req0_v = '0, req1_v = '0, we0_v = '0, we1_v = '0, miso_v = '0;
  logic [15:0] addr0_v [2];
  logic [15:0] addr1_v [2];
  logic [7:0]  wdata0_v [2];
  logic [7:0]  wdata1_v [2];
  wire  [1:0]  ack0_v, ack1_v, busy_v, cs_v, sck_v, mosi_v;
  wire  [7:0]  rdata_v [2];

  spi_ram_arbiter #(.SCK_HALF(1)) dut1 (
    .clk(clk), .rst(rst_v[0]), .req0(req0_v[0]), .req1(req1_v[0]),
    .we0(we0_v[0]), .we1(we1_v[0]), .addr0(addr0_v[0]), .addr1(addr1_v[0]),
    .wdata0(wdata0_v[0]), .wdata1(wdata1_v[0]), .ack0(ack0_v[0]), .ack1(ack1_v[0]),
    .rdata(rdata_v[0]), .busy(busy_v[0]), .spi_cs_n(cs_v[0]), .spi_sck(sck_v[0]),
    .spi_mosi(mosi_v[0]), .spi_miso(miso_v[0])
  );

  spi_ram_arbiter #(.SCK_HALF(2)) dut2 (
    .clk(clk), .rst(rst_v[1]), .req0(req0_v[1]), .req1(req1_v[1]),
    .we0(we0_v[1]), .we1(we1_v[1]), .addr0(addr0_v[1]), .addr1(addr1_v[1]),
    .wdata0(wdata0_v[1]), .wdata1(wdata1_v[1]), .ack0(ack0_v[1]), .ack1(ack1_v[1]),
    .rdata(rdata_v[1]), .busy(busy_v[1]), .spi_cs_n(cs_v[1]), .spi_sck(sck_v[1]),
    .spi_mosi(mosi_v[1]), .spi_miso(miso_v[1])
  );

  int n_chk = 0;
  int n_fail = 0;

  // slave model / monitor state, one slot per instance
  logic [1:0]  prev_cs = 2'b11, prev_sck = '0, prev_mosi = '0, prev_ack = '0;
  logic [7:0]  sbyte [2];
  logic [31:0] sr [2];
  logic [31:0] tx_bits [2][64];
  int          tx_rises [2][64];
  int          rises [2], run [2], phase_err [2], mosi_err [2];
  int          tx_n [2], ack_tot [2], dbl_ack [2];

  // reference model state
  int          lg [2];
  logic [7:0]  mrdata [2];

  function automatic int hh(input int d);
    return (d == 0) ? 1 : 2;
  endfunction

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (cs_v[d]) begin
        if (!prev_cs[d]) begin
          tx_bits[d][tx_n[d] % 64]  = sr[d];
          tx_rises[d][tx_n[d] % 64] = rises[d];
          tx_n[d]++;
        end
        rises[d] = 0;
        sr[d]    = '0;
        run[d]   = 0;
      end else begin
        // while selected, mosi may only move together with a falling sck
        if (!prev_cs[d] && (mosi_v[d] !== prev_mosi[d]) && !(prev_sck[d] && !sck_v[d]))
          mosi_err[d]++;
        if (sck_v[d] && !prev_sck[d]) begin
          if (rises[d] > 0 && run[d] != hh(d)) phase_err[d]++;
          sr[d] = {sr[d][30:0], mosi_v[d]};
          rises[d]++;
          run[d] = 1;
        end else if (!sck_v[d] && prev_sck[d]) begin
          if (run[d] != hh(d)) phase_err[d]++;
          run[d] = 1;
        end else begin
          run[d]++;
        end
      end
      if (rises[d] >= 24 && rises[d] < 32) miso_v[d] = sbyte[d][31 - rises[d]];
      else miso_v[d] = 1'b0;
      if (ack0_v[d] || ack1_v[d]) begin
        ack_tot[d]++;
        if (prev_ack[d]) dbl_ack[d]++;
      end
      prev_cs[d]   = cs_v[d];
      prev_sck[d]  = sck_v[d];
      prev_mosi[d] = mosi_v[d];
      prev_ack[d]  = ack0_v[d] | ack1_v[d];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic set_port(input int d, input int p, input bit we, input logic [15:0] a,
                          input logic [7:0] w);
    if (p == 0) begin
      we0_v[d] = we; addr0_v[d] = a; wdata0_v[d] = w; req0_v[d] = 1'b1;
    end else begin
      we1_v[d] = we; addr1_v[d] = a; wdata1_v[d] = w; req1_v[d] = 1'b1;
    end
  endtask

  // Called in an IDLE cycle with requests already driven; returns in the next IDLE cycle.
  task automatic wait_txn(input int d, input bit late, input int exp_port,
                          input logic [31:0] exp_bits, input logic [7:0] exp_rdata);
    int cyc, gport, base;
    base  = tx_n[d];
    cyc   = 0;
    gport = -1;
    while (gport < 0 && cyc < 400) begin
      @(negedge clk); #1;
      cyc++;
      if (late && cyc == 1) begin
        addr0_v[d] = ~addr0_v[d]; wdata0_v[d] = ~wdata0_v[d]; we0_v[d] = ~we0_v[d];
      end
      if (ack0_v[d]) gport = 0;
      else if (ack1_v[d]) gport = 1;
    end
    req0_v[d] = 1'b0;
    req1_v[d] = 1'b0;
    chk("grant", gport, exp_port);
    chk("ack_latency", cyc, 3 + 64 * hh(d));
    chk("rdata", rdata_v[d], exp_rdata);
    chk("busy_done", busy_v[d], 1);
    @(negedge clk); #1;
    chk("ack_pulse", {ack0_v[d], ack1_v[d]}, 0);
    chk("busy_idle", busy_v[d], 0);
    chk("tx_count", tx_n[d] - base, 1);
    chk("mosi_stream", tx_bits[d][(tx_n[d] + 63) % 64], exp_bits);
    chk("sck_rises", tx_rises[d][(tx_n[d] + 63) % 64], 32);
  endtask

  typedef struct {
    int          port;
    bit          we;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  sb;
    logic [31:0] bits;
    logic [7:0]  rdata;
  } vec_t;

  vec_t vecs [6];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          mask, ep, cyc, gport, ab;
    bit          w0, w1, ew;
    logic [15:0] a0, a1, ea;
    logic [7:0]  d0, d1, ed, sb, erd;

    vecs[0] = '{0, 1'b1, 16'h1234, 8'hA5, 8'h00, 32'h021234A5, 8'h00};
    vecs[1] = '{1, 1'b0, 16'h00FF, 8'h00, 8'h5A, 32'h0300FF00, 8'h5A};
    vecs[2] = '{0, 1'b1, 16'hFFFF, 8'h3C, 8'h77, 32'h02FFFF3C, 8'h5A};
    vecs[3] = '{1, 1'b0, 16'h0000, 8'hEE, 8'h81, 32'h03000000, 8'h81};
    vecs[4] = '{0, 1'b0, 16'h8001, 8'h12, 8'hFF, 32'h03800100, 8'hFF};
    vecs[5] = '{1, 1'b1, 16'hABCD, 8'h00, 8'h55, 32'h02ABCD00, 8'hFF};

    for (int d = 0; d < 2; d++) begin
      addr0_v[d] = '0; addr1_v[d] = '0; wdata0_v[d] = '0; wdata1_v[d] = '0;
      sbyte[d] = '0; lg[d] = 1; mrdata[d] = '0;
    end

    repeat (2) @(negedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("rst_cs_n", cs_v[d], 1);
      chk("rst_sck", sck_v[d], 0);
      chk("rst_mosi", mosi_v[d], 0);
      chk("rst_busy", busy_v[d], 0);
      chk("rst_ack", {ack0_v[d], ack1_v[d]}, 0);
      chk("rst_rdata", rdata_v[d], 0);
    end
    rst_v = 2'b00;
    @(negedge clk); #1;

    for (int i = 0; i < 6; i++) begin
      sbyte[0] = vecs[i].sb;
      set_port(0, vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata);
      wait_txn(0, 1'b0, vecs[i].port, vecs[i].bits, vecs[i].rdata);
      lg[0] = vecs[i].port;
      mrdata[0] = vecs[i].rdata;
      if (i == 1) begin
        repeat (10) @(negedge clk);
        #1;
        chk("rdata_hold", rdata_v[0], 8'h5A);
      end
    end

    // inputs change one cycle after grant
    set_port(0, 0, 1'b1, 16'h4321, 8'h99);
    wait_txn(0, 1'b1, 0, 32'h02432199, mrdata[0]);
    lg[0] = 0;

    // both ports requesting continuously
    set_port(0, 0, 1'b1, 16'h1111, 8'h11);
    set_port(0, 1, 1'b0, 16'h2222, 8'h00);
    sbyte[0] = 8'hC3;
    for (int k = 0; k < 4; k++) begin
      cyc = 0;
      gport = -1;
      while (gport < 0 && cyc < 400) begin
        @(negedge clk); #1;
        cyc++;
        if (ack0_v[0]) gport = 0;
        else if (ack1_v[0]) gport = 1;
      end
      if (k == 3) begin
        req0_v[0] = 1'b0;
        req1_v[0] = 1'b0;
      end
      lg[0] = 1 - lg[0];
      chk("contention_grant", gport, lg[0]);
      chk("contention_gap", cyc, (k == 0) ? 67 : 68);
      chk("contention_stream", tx_bits[0][(tx_n[0] + 63) % 64],
          (lg[0] == 0) ? 32'h02111111 : 32'h03222200);
      if (lg[0] == 1) mrdata[0] = 8'hC3;
      chk("contention_rdata", rdata_v[0], mrdata[0]);
    end
    @(negedge clk); #1;
    chk("contention_ack_pulse", {ack0_v[0], ack1_v[0]}, 0);

    // randomized traffic against the reference model
    for (int i = 0; i < 12; i++) begin
      mask = $urandom_range(1, 3);
      w0 = 1'($urandom_range(0, 1)); w1 = 1'($urandom_range(0, 1));
      a0 = 16'($urandom); a1 = 16'($urandom);
      d0 = 8'($urandom); d1 = 8'($urandom); sb = 8'($urandom);
      sbyte[0] = sb;
      if (mask[0]) set_port(0, 0, w0, a0, d0);
      if (mask[1]) set_port(0, 1, w1, a1, d1);
      ep  = (mask == 1) ? 0 : (mask == 2) ? 1 : 1 - lg[0];
      ew  = (ep == 1) ? w1 : w0;
      ea  = (ep == 1) ? a1 : a0;
      ed  = (ep == 1) ? d1 : d0;
      erd = ew ? mrdata[0] : sb;
      wait_txn(0, 1'b0, ep, {(ew ? 8'h02 : 8'h03), ea, (ew ? ed : 8'h00)}, erd);
      lg[0] = ep;
      mrdata[0] = erd;
    end

    // reset in the middle of a transfer
    set_port(0, 0, 1'b1, 16'h5555, 8'h66);
    sbyte[0] = 8'h00;
    ab = ack_tot[0];
    repeat (20) @(negedge clk);
    #1;
    chk("reset_mid_busy", busy_v[0], 1);
    rst_v[0] = 1'b1;
    req0_v[0] = 1'b0;
    @(negedge clk); #1;
    chk("reset_cs_n", cs_v[0], 1);
    chk("reset_sck", sck_v[0], 0);
    chk("reset_mosi", mosi_v[0], 0);
    chk("reset_busy", busy_v[0], 0);
    chk("reset_rdata", rdata_v[0], 0);
    chk("reset_ack", {ack0_v[0], ack1_v[0]}, 0);
    @(negedge clk); #1;
    rst_v[0] = 1'b0;
    chk("reset_no_ack", ack_tot[0] - ab, 0);
    lg[0] = 1;
    mrdata[0] = 8'h00;
    set_port(0, 0, 1'b0, 16'h0042, 8'h00);
    sbyte[0] = 8'h99;
    wait_txn(0, 1'b0, 0, 32'h03004200, 8'h99);

    // slower serial clock
    set_port(1, 1, 1'b0, 16'h0A0B, 8'h00);
    sbyte[1] = 8'hE7;
    wait_txn(1, 1'b0, 1, 32'h030A0B00, 8'hE7);
    repeat (3) @(negedge clk);
    #1;

    for (int d = 0; d < 2; d++) begin
      chk("sck_phase", phase_err[d], 0);
      chk("mosi_timing", mosi_err[d], 0);
      chk("ack_double", dbl_ack[d], 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
